// File: rtl/conv1_window_sched.sv
// Frame scheduler for conv1: buffers two rows, builds 3x3 windows, issues them on credit, queues results.
// Optional CONV1_SCHED_PERF_EN adds the perf_in_stall / perf_out_stall counters.
module conv1_window_sched #(
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int PIX_W      = 24,
    parameter int OUT_W      = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             frame_done,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_data,
    output logic             in_ready,
    output logic             conv_valid,
    output logic [215:0]     conv_act,
    input  logic             conv_ready,
    input  logic [OUT_W-1:0] conv_result,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready,
    output logic             err_unexp
`ifdef CONV1_SCHED_PERF_EN
    ,
    output logic [31:0]      perf_in_stall,
    output logic [31:0]      perf_out_stall
`endif
);
    // state | meaning
    // IDLE  | waiting for start
    // LOAD  | accepting the frame's pixels, issuing windows
    // DRAIN | all pixels in; waiting for issue, conv1 and FIFO to empty
    // DONE  | one-cycle frame_done pulse
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    state_t              state;
    logic [XW-1:0]       x;
    logic [YW-1:0]       y;
    logic [PIX_W-1:0]    row_a [IMG_W];
    logic [PIX_W-1:0]    row_b [IMG_W];
    logic [PIX_W-1:0]    win [3][3];
    logic [OUT_W-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       fifo_count, inflight;
    logic [CW+1:0]       credit_sum;
    logic                accept, capture, pop;

    // conv_valid doubles as the single-entry issue-pending flag
    assign credit_sum = {2'b00, fifo_count} + {2'b00, inflight} + (CW+2)'(conv_valid);
    assign in_ready   = (state == S_LOAD) && (credit_sum < (CW+2)'(FIFO_DEPTH));
    assign accept     = in_valid && in_ready;
    assign capture    = conv_ready && (inflight != '0);
    assign out_valid  = (fifo_count != '0);
    assign pop        = out_valid && out_ready;
    assign out_data   = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            x          <= '0;
            y          <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state <= S_LOAD;
                    busy  <= 1'b1;
                    x     <= '0;
                    y     <= '0;
                end
                S_LOAD: if (accept) begin
                    if (x == X_LAST) begin
                        x <= '0;
                        if (y == Y_LAST) state <= S_DRAIN;
                        else             y     <= y + YW'(1);
                    end else begin
                        x <= x + XW'(1);
                    end
                end
                S_DRAIN: if (!conv_valid && inflight == '0 && fifo_count == '0) begin
                    state      <= S_DONE;
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // row_a holds row y-2, row_b row y-1; the new column enters the window at kx=2
    always_ff @(posedge clk) begin
        if (rst) begin
            conv_valid <= 1'b0;
            for (int i = 0; i < IMG_W; i++) begin
                row_a[i] <= '0;
                row_b[i] <= '0;
            end
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
        end else begin
            conv_valid <= accept && (x >= XW'(2)) && (y >= YW'(2));
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= row_a[x];
                win[1][2] <= row_b[x];
                win[2][2] <= in_data;
                row_a[x]  <= row_b[x];
                row_b[x]  <= in_data;
            end
        end
    end

    always_comb begin
        conv_act = '0;
        for (int c = 0; c < 3; c++)
            for (int ky = 0; ky < 3; ky++)
                for (int kx = 0; kx < 3; kx++)
                    conv_act[72*c + 8*(3*ky + kx) +: 8] = win[ky][kx][8*c +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight   <= '0;
            err_unexp  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (conv_valid && !capture)      inflight <= inflight + CW'(1);
            else if (!conv_valid && capture) inflight <= inflight - CW'(1);
            if (conv_ready && inflight == '0) err_unexp <= 1'b1;
            if (capture) begin
                fifo_mem[wr_ptr] <= conv_result;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (capture && !pop)      fifo_count <= fifo_count + CW'(1);
            else if (!capture && pop) fifo_count <= fifo_count - CW'(1);
        end
    end

`ifdef CONV1_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || (state == S_IDLE && start)) begin
            perf_in_stall  <= '0;
            perf_out_stall <= '0;
        end else begin
            if (state == S_LOAD && in_valid && !in_ready && perf_in_stall != '1)
                perf_in_stall <= perf_in_stall + 32'd1;
            if (out_valid && !out_ready && perf_out_stall != '1)
                perf_out_stall <= perf_out_stall + 32'd1;
        end
    end
`endif

endmodule
